// File: rtl/io_enq_policy_if.sv
// Enqueue-policy bundle between dispatch, the issue-queue entry array and select logic.
// The slave modport is the policy block; the master modport is its environment.
interface io_enq_policy_if #(
   parameter int QUEUE_SIZE = 8,
   parameter int CNT_W      = $clog2(QUEUE_SIZE + 1)
);
   logic                  flush;
   logic                  enq_valid;
   logic                  enq_ready;
   logic                  enq_fire;
   logic [QUEUE_SIZE-1:0] enq_ptr_oh;
   logic [QUEUE_SIZE-1:0] enq_valid_oh;
   logic                  deq_fire;
   logic [QUEUE_SIZE-1:0] deq_valid_oh;
   logic [QUEUE_SIZE-1:0] valid_dec;
   logic [CNT_W-1:0]      free_cnt;
   logic                  full;
   logic                  empty;

   modport slave (
      input  flush, enq_valid, deq_fire, deq_valid_oh,
      output enq_ready, enq_fire, enq_ptr_oh, enq_valid_oh, valid_dec, free_cnt, full, empty
   );

   modport master (
      output flush, enq_valid, deq_fire, deq_valid_oh,
      input  enq_ready, enq_fire, enq_ptr_oh, enq_valid_oh, valid_dec, free_cnt, full, empty
   );
endinterface

// File: rtl/io_enq_policy.sv
// Issue-queue enqueue policy: registered occupancy/pointer/count (1-cycle update), next slot is first free at or after ptr.
// enq_ready drops when full or flushing; IO_ENQ_FULL_BYPASS_EN lets a full queue accept into the slot freed this cycle.
module io_enq_policy #(
   parameter int QUEUE_SIZE = 8,
   parameter int CNT_W      = $clog2(QUEUE_SIZE + 1)
) (
   input logic            clock,
   input logic            reset,
   io_enq_policy_if.slave io
);

   logic [QUEUE_SIZE-1:0] valid_q;
   logic [QUEUE_SIZE-1:0] ptr_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  full_w;
   logic                  empty_w;
   logic                  ready_w;
   logic                  fire_w;
   logic [QUEUE_SIZE-1:0] free_oh;
   logic [QUEUE_SIZE-1:0] wr_oh;
   logic [QUEUE_SIZE-1:0] valid_next;
   logic [CNT_W-1:0]      cnt_next;
   logic [QUEUE_SIZE-1:0] base_oh;
   logic [QUEUE_SIZE-1:0] avail;
   logic [QUEUE_SIZE-1:0] avail_hi;
   logic [QUEUE_SIZE-1:0] pick;
   logic [QUEUE_SIZE-1:0] ptr_next;

   assign full_w  = &valid_q;
   assign empty_w = ~|valid_q;

   // A free aimed at an empty slot must not touch the count.
   assign free_oh = (io.deq_fire ? io.deq_valid_oh : '0) & valid_q;

`ifdef IO_ENQ_FULL_BYPASS_EN
   assign ready_w = (~full_w | (io.deq_fire & |free_oh)) & ~io.flush;
   assign wr_oh   = ~fire_w ? '0 : (full_w ? free_oh : ptr_q);
`else
   assign ready_w = ~full_w & ~io.flush;
   assign wr_oh   = fire_w ? ptr_q : '0;
`endif

   assign fire_w     = io.enq_valid & ready_w;
   assign valid_next = (valid_q & ~free_oh) | wr_oh;
   assign cnt_next   = cnt_q + CNT_W'(|free_oh) - CNT_W'(fire_w);

   // Round-robin search: free slots at or above the base first, else lowest free slot overall.
   assign base_oh  = fire_w ? {ptr_q[QUEUE_SIZE-2:0], ptr_q[QUEUE_SIZE-1]} : ptr_q;
   assign avail    = ~valid_next;
   assign avail_hi = avail & ~(base_oh - QUEUE_SIZE'(1));

   always_comb begin
      pick = '0;
      if (|avail_hi) begin
         pick = avail_hi & (~avail_hi + QUEUE_SIZE'(1));
      end else begin
         pick = avail & (~avail + QUEUE_SIZE'(1));
      end
      ptr_next = (|avail) ? pick : ptr_q;
   end

   always_ff @(posedge clock) begin
      if (reset || io.flush) begin
         valid_q <= '0;
         ptr_q   <= QUEUE_SIZE'(1);
         cnt_q   <= CNT_W'(QUEUE_SIZE);
      end else begin
         valid_q <= valid_next;
         ptr_q   <= ptr_next;
         cnt_q   <= cnt_next;
      end
   end

   assert property (@(posedge clock) disable iff (reset)
      cnt_q == CNT_W'(QUEUE_SIZE - $countones(valid_q)));

   assign io.enq_ready    = ready_w;
   assign io.enq_fire     = fire_w;
   assign io.enq_ptr_oh   = ptr_q;
   assign io.enq_valid_oh = wr_oh;
   assign io.valid_dec    = valid_q;
   assign io.free_cnt     = cnt_q;
   assign io.full         = full_w;
   assign io.empty        = empty_w;

endmodule

// File: tb/tb_io_enq_policy.sv
// Bench for io_enq_policy: directed scenarios then random traffic against a slot-array reference model.
module tb_io_enq_policy;
   localparam int Q  = 8;
   localparam int CW = $clog2(Q + 1);

   logic clock = 1'b0;
   logic reset = 1'b1;

   io_enq_policy_if #(.QUEUE_SIZE(Q), .CNT_W(CW)) io ();

   io_enq_policy #(.QUEUE_SIZE(Q), .CNT_W(CW)) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: per-slot occupancy flags and the enqueue pointer as a slot index.
   bit occ [Q];
   int mptr = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic step(input bit rst, input bit fl, input bit ev, input bit df, input int didx);
      bit             full_m;
      bit             rdy;
      bit             fire;
      int             slot;
      int             nocc;
      int             base;
      logic [Q-1:0]   vvec;
      logic [Q-1:0]   pvec;
      logic [Q-1:0]   wr;
      logic [Q-1:0]   one;
      one = 1;
      reset           = rst;
      io.flush        = fl;
      io.enq_valid    = ev;
      io.deq_fire     = df;
      io.deq_valid_oh = one << didx;
      #1;
      full_m = 1;
      nocc   = 0;
      vvec   = '0;
      for (int i = 0; i < Q; i++) begin
         vvec[i] = occ[i];
         if (occ[i]) nocc++;
         else        full_m = 0;
      end
      rdy = !full_m && !fl;
`ifdef IO_ENQ_FULL_BYPASS_EN
      if (full_m && df && occ[didx] && !fl) rdy = 1;
`endif
      fire = ev && rdy;
      slot = full_m ? didx : mptr;
      wr   = fire ? (one << slot) : '0;
      pvec = one << mptr;
      if (!rst) begin
         check_val("enq_ready",    io.enq_ready,    rdy);
         check_val("enq_fire",     io.enq_fire,     fire);
         check_val("enq_valid_oh", io.enq_valid_oh, wr);
         check_val("enq_ptr_oh",   io.enq_ptr_oh,   pvec);
         check_val("valid_dec",    io.valid_dec,    vvec);
         check_val("free_cnt",     io.free_cnt,     Q - nocc);
         check_val("full",         io.full,         full_m);
         check_val("empty",        io.empty,        nocc == 0);
      end
      @(posedge clock);
      if (rst || fl) begin
         for (int i = 0; i < Q; i++) occ[i] = 0;
         mptr = 0;
      end else begin
         if (df && occ[didx]) occ[didx] = 0;
         if (fire) occ[slot] = 1;
         base = fire ? (mptr + 1) % Q : mptr;
         for (int i = 0; i < Q; i++) begin
            if (!occ[(base + i) % Q]) begin
               mptr = (base + i) % Q;
               break;
            end
         end
      end
      #1;
   endtask

   task automatic idle();
      reset        = 1'b0;
      io.flush     = 1'b0;
      io.enq_valid = 1'b0;
      io.deq_fire  = 1'b0;
      #1;
   endtask

   initial begin
      io.flush        = 1'b0;
      io.enq_valid    = 1'b0;
      io.deq_fire     = 1'b0;
      io.deq_valid_oh = '0;

      // Reset for two cycles.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      idle();
      check_val("rst_ptr",   io.enq_ptr_oh, 8'h01);
      check_val("rst_valid", io.valid_dec,  8'h00);
      check_val("rst_cnt",   io.free_cnt,   8);
      check_val("rst_ready", io.enq_ready,  1);
      check_val("rst_empty", io.empty,      1);

      // Fill with back-to-back enqueues.
      for (int i = 0; i < Q; i++) step(0, 0, 1, 0, 0);
      idle();
      check_val("fill_full",  io.full,       1);
      check_val("fill_ready", io.enq_ready,  0);
      check_val("fill_cnt",   io.free_cnt,   0);
      check_val("fill_ptr",   io.enq_ptr_oh, 8'h80);

      // Free slot 4 from full: pointer search wraps.
      step(0, 0, 0, 1, 4);
      idle();
      check_val("wrap_valid", io.valid_dec,  8'hEF);
      check_val("wrap_ptr",   io.enq_ptr_oh, 8'h10);
      check_val("wrap_cnt",   io.free_cnt,   1);
      check_val("wrap_ready", io.enq_ready,  1);

      // Build 0x0F with pointer 0x10, then enqueue and free slot 0 together.
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      idle();
      check_val("same_valid", io.valid_dec,  8'h1E);
      check_val("same_ptr",   io.enq_ptr_oh, 8'h20);
      check_val("same_cnt",   io.free_cnt,   4);

      // Reach 0x3C, then flush with an enqueue pending.
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1);
      idle();
      check_val("pre_flush_valid", io.valid_dec, 8'h3C);
      io.flush = 1'b1; io.enq_valid = 1'b1; #1;
      check_val("flush_ready", io.enq_ready, 0);
      step(0, 1, 1, 1, 2);
      idle();
      check_val("flush_valid", io.valid_dec,  8'h00);
      check_val("flush_ptr",   io.enq_ptr_oh, 8'h01);
      check_val("flush_cnt",   io.free_cnt,   8);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 1, 1, 1, 0);
      idle();
      check_val("rstfl_valid", io.valid_dec,  8'h00);
      check_val("rstfl_ptr",   io.enq_ptr_oh, 8'h01);
      check_val("rstfl_cnt",   io.free_cnt,   8);

      // Full queue, enqueue while slot 2 is freed.
      for (int i = 0; i < Q; i++) step(0, 0, 1, 0, 0);
      io.enq_valid = 1'b1; io.deq_fire = 1'b1; io.deq_valid_oh = 8'h04; #1;
`ifdef IO_ENQ_FULL_BYPASS_EN
      check_val("byp_ready", io.enq_ready,    1);
      check_val("byp_wr",    io.enq_valid_oh, 8'h04);
`else
      check_val("byp_ready", io.enq_ready,    0);
`endif
      step(0, 0, 1, 1, 2);
      idle();
`ifdef IO_ENQ_FULL_BYPASS_EN
      check_val("byp_valid", io.valid_dec, 8'hFF);
      check_val("byp_cnt",   io.free_cnt,  0);
`else
      check_val("byp_valid", io.valid_dec, 8'hFB);
`endif

      // Random traffic, including frees of empty slots and ignored deq vectors.
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 50,
              int'($urandom_range(0, Q - 1)));
      end
      step(0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/io_enq_policy.md
Name: io_enq_policy

Overview:
- Enqueue-side allocation policy for an issue queue; the producer-side counterpart of the dequeue-pointer policy.
- Owns the queue occupancy vector and decides which slot the next dispatched uop is written to: first free slot, round-robin from the current enqueue pointer.
- Exposes the registered occupancy vector, enqueue pointer and one-hot write strobe for the dequeue policy and the queue payload array.
- Sits between dispatch (enq handshake) and the issue-queue entry array and select logic (dequeue frees).

Parameters:
QUEUE_SIZE, 8, number of issue-queue entries; must be >= 2.
CNT_W, $clog2(QUEUE_SIZE+1), width of the free-slot counter.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  pipeline flush; empties the queue at the next edge.
enq_valid  input  1  dispatch presents a uop.
enq_ready  output  1  a slot is available this cycle.
enq_fire  output  1  enq_valid & enq_ready.
enq_ptr_oh  output  QUEUE_SIZE  registered one-hot slot for the next enqueue.
enq_valid_oh  output  QUEUE_SIZE  one-hot write strobe this cycle; zero when enq_fire=0.
deq_fire  input  1  an entry issues this cycle.
deq_valid_oh  input  QUEUE_SIZE  one-hot entry being freed; ignored when deq_fire=0.
valid_dec  output  QUEUE_SIZE  registered occupancy vector.
free_cnt  output  CNT_W  registered count of free slots.
full  output  1  valid_dec all ones.
empty  output  1  valid_dec all zeros.

Behaviour:
- Reset: synchronous, active-high. valid_dec=0, enq_ptr_oh=1 (bit 0), free_cnt=QUEUE_SIZE; so full=0, empty=1, enq_ready=1.
- Priority each edge: reset > flush > normal update.
- Combinational outputs:
  - full, empty decoded from valid_dec.
  - enq_ready = ~full & ~flush; enqueue is refused during the flush cycle.
  - enq_valid_oh = enq_fire ? enq_ptr_oh : 0.
- Free mask: free_oh = (deq_fire ? deq_valid_oh : 0) & valid_dec. A free aimed at an already-invalid slot is a no-op.
- Occupancy update: valid_next = (valid_dec & ~free_oh) | enq_valid_oh.
- Counter update: free_cnt_next = free_cnt + |free_oh - enq_fire.
  - Enq and deq in the same cycle leaves free_cnt unchanged.
  - free_cnt never wraps; an invariant check requires free_cnt == QUEUE_SIZE - popcount(valid_dec).
- Pointer update:
  - Search base = enq_fire ? rotate-left-by-1(enq_ptr_oh) : enq_ptr_oh.
  - enq_ptr_oh_next = first zero of valid_next at or after the base, wrapping from MSB to bit 0.
  - If valid_next is all ones, enq_ptr_oh holds its value.
- Flush: next edge gives valid_dec=0, enq_ptr_oh=1, free_cnt=QUEUE_SIZE. A deq_fire in the flush cycle is discarded.
- Latency: a slot freed at edge N is enqueueable in cycle N+1. There is no same-cycle reuse unless the optional feature below is enabled.
- Outputs are registered, so the dequeue side sees occupancy one cycle after the enq/deq event.

Optional Feature:
IO_ENQ_FULL_BYPASS_EN.
- Defined:
  - enq_ready = (~full | (deq_fire & |free_oh)) & ~flush.
  - When full, the enqueue writes the slot being freed: enq_valid_oh = free_oh.
  - valid_dec stays all ones and free_cnt stays 0.
- Undefined: enq_ready = ~full & ~flush, as in Behaviour.

Test Plan:
1. Reset asserted 2 cycles then released -> enq_ptr_oh=8'h01, valid_dec=8'h00, free_cnt=8, enq_ready=1, empty=1.
2. 8 back-to-back enq_valid, no deq -> valid_dec steps 01,03,07,...,FF; after 8th edge full=1, enq_ready=0, free_cnt=0, enq_ptr_oh=8'h80.
3. From full, deq_fire with deq_valid_oh=8'h10 -> next cycle valid_dec=8'hEF, enq_ptr_oh=8'h10 (wrapped search), free_cnt=1, enq_ready=1.
4. valid_dec=8'h0F, enq_ptr_oh=8'h10, enq_fire and deq_valid_oh=8'h01 same cycle -> valid_dec=8'h1E, enq_ptr_oh=8'h20, free_cnt stays 4.
5. valid_dec=8'h3C with flush and enq_valid both high -> enq_ready=0 that cycle; next cycle valid_dec=0, enq_ptr_oh=8'h01, free_cnt=8. Repeat with reset and flush together -> same reset values.
6. Full, enq_valid=1, deq_fire with deq_valid_oh=8'h04:
   - With IO_ENQ_FULL_BYPASS_EN: enq_ready=1, enq_valid_oh=8'h04, valid_dec stays FF, free_cnt=0.
   - Without it: enq_ready=0, valid_dec=8'hFB next cycle.
